// File: rtl/data_mem_ring.sv
// data_mem_ring: circular sample memory between the serial deframer and the filter datapath.
// Writes land at an auto-incrementing, wrapping pointer. Reads are addressed relative to the
// newest sample and return one cycle later. Fill level saturates at DEPTH, after which the
// oldest sample is overwritten.
// Optional build macro: ZERO_DETECT_EN adds a zero-run counter that drives allzeros.
// Without it, no counter is built and allzeros is tied low.
module data_mem_ring #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 8,
   parameter int ZERO_RUN = 800,
   parameter int CNT_W    = 12
) (
   input  logic              Sclk,
   input  logic              Reset,
   input  logic              Frame,
   input  logic              input_ready,
   input  logic              write_enable,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] Read_Offset,
   output logic [DATA_W-1:0] data_stored,
   output logic              data_valid,
   output logic              rd_err,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic [ADDR_W:0]   fill_count,
   output logic              full,
   output logic              allzeros
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FILL_MAX = {1'b1, {ADDR_W{1'b0}}};

   // The zero-run threshold must fit in the counter.
   if (ZERO_RUN >= (1 << CNT_W)) begin : g_bad_zero_run
      $error("data_mem_ring: ZERO_RUN must be < 2**CNT_W");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   logic              wr_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              in_range;

   assign wr_en    = input_ready && write_enable && Frame;
   // Both the read address and the range check use the pre-write state, so a same-cycle
   // write is never visible to the read issued alongside it.
   assign rd_addr  = wr_ptr_q - ADDR_W'(1) - Read_Offset;
   assign in_range = ({1'b0, Read_Offset} < fill_q);

   // Next write pointer and fill level.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + (ADDR_W+1)'(1);
         end
      end
   end

   // Next read-port outputs; out-of-range reads return zero with an error flag.
   always_comb begin
      rdata_d = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (read_enable) begin
         valid_d = 1'b1;
         if (in_range) begin
            rdata_d = mem_q[rd_addr];
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Sample storage; contents survive reset.
   always_ff @(posedge Sclk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   // Pointer, fill level and registered read port.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         rdata_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         rdata_q  <= rdata_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign wr_ptr      = wr_ptr_q;
   assign fill_count  = fill_q;
   assign full        = (fill_q == FILL_MAX);
   assign data_stored = rdata_q;
   assign data_valid  = valid_q;
   assign rd_err      = err_q;

`ifdef ZERO_DETECT_EN
   localparam logic [CNT_W-1:0] RUN_C = CNT_W'(ZERO_RUN);

   logic [CNT_W-1:0] zcnt_q, zcnt_d;
   logic             zflag_q, zflag_d;

   // Zero-run counter: every strobed sample counts, whether or not it is stored.
   always_comb begin
      zcnt_d  = zcnt_q;
      zflag_d = zflag_q;
      if (input_ready) begin
         if (data_in == '0) begin
            if (zcnt_q != RUN_C) begin
               zcnt_d = zcnt_q + CNT_W'(1);
            end
            zflag_d = (zcnt_d == RUN_C);
         end else begin
            zcnt_d  = '0;
            zflag_d = 1'b0;
         end
      end
   end

   // Zero-run state register.
   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         zcnt_q  <= '0;
         zflag_q <= 1'b0;
      end else begin
         zcnt_q  <= zcnt_d;
         zflag_q <= zflag_d;
      end
   end

   assign allzeros = zflag_q;
`else
   assign allzeros = 1'b0;
`endif

endmodule
